// File: rtl/secuenciador_contador.sv
// secuenciador_contador: command sequencer for the 4-bit counter.
// Queues {mode, data, len} commands in a circular FIFO and replays each one as a
// burst of len enabled counter cycles. It also keeps a saturating tally of the
// counter's rco pulses.
module secuenciador_contador #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [3:0]       cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             enable,
  output logic [1:0]       mode,
  output logic [3:0]       D,
  input  logic             rco,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rco_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [3:0]       data;
    logic [LEN_W-1:0] len;
  } cmd_t;

  // FIFO storage and bookkeeping
  cmd_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;
  cmd_t           head;

  // Sequencer state
  state_t           state;
  state_t           state_next;
  logic [1:0]       mode_r;
  logic [3:0]       d_r;
  logic [LEN_W-1:0] rem;
  logic             null_cmd;
  logic             last_run;

  // Next values of the registered counter-side outputs
  logic       enable_d;
  logic [1:0] mode_d;
  logic [3:0] d_d;
  logic       done_d;

  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  // Every path into FETCH guarantees at least one queued command, so FETCH
  // always pops.
  assign pop       = (state == FETCH);
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || (count != '0);
  assign null_cmd  = (head.len == '0);
  assign last_run  = (rem == LEN_W'(1));

  // Command storage write port.
  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{mode: cmd_mode, data: cmd_data, len: cmd_len};
    end
  end

  // FIFO pointers and occupancy; reset discards everything queued.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  // NOTE: every combinational output gets a default assignment first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (count != '0) state_next = FETCH;
      end
      FETCH: begin
        if (null_cmd) begin
          // The head is consumed this cycle, so more work remains only if
          // something sits behind it.
          state_next = (count > CW'(1)) ? FETCH : IDLE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_run) state_next = (count != '0) ? FETCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Burst context: latch the popped command and count down its length.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_r <= '0;
      d_r    <= '0;
      rem    <= '0;
    end else if (state == FETCH) begin
      mode_r <= head.mode;
      d_r    <= head.data;
      rem    <= head.len;
    end else if (state == RUN) begin
      // RUN is left when rem reaches 1, so this never wraps below zero.
      rem <= rem - LEN_W'(1);
    end
  end

  // FSM output logic: the values the counter should see in the next cycle.
  always_comb begin
    enable_d = 1'b0;
    mode_d   = 2'b00;
    d_d      = 4'h0;
    if (state_next == RUN) begin
      enable_d = 1'b1;
      // On the FETCH->RUN edge the burst context is still being loaded, so
      // take the fields straight from the FIFO head.
      if (state == FETCH) begin
        mode_d = head.mode;
        d_d    = head.data;
      end else begin
        mode_d = mode_r;
        d_d    = d_r;
      end
    end
    done_d = ((state == FETCH) && null_cmd) || ((state == RUN) && last_run);
  end

  // Registered counter-side outputs and completion pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      enable <= 1'b0;
      mode   <= 2'b00;
      D      <= 4'h0;
      done   <= 1'b0;
    end else begin
      enable <= enable_d;
      mode   <= mode_d;
      D      <= d_d;
      done   <= done_d;
    end
  end

  // Saturating count of cycles with rco high, independent of the FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rco_count <= '0;
    end else if (rco && (rco_count != 8'hFF)) begin
      rco_count <= rco_count + 8'd1;
    end
  end

endmodule
